pc_fetch_sequencer: RTL and testbench
=====================================

// Module: pc_fetch_sequencer
// PURPOSE
//  Owns the program counter and sequences instruction fetch for the single-cycle core.
//  Each instruction runs through: issue fetch -> wait for instruction memory -> hold
//  instruction for execute -> commit NextPC (from NextPClogic) into CurrentPC.
//  Sits between NextPClogic, the instruction memory request/response port and the
//  hazard/halt control. Adds stall, halt, misalignment fault and a retired-instruction counter.
// PARAMETERS
//  RESET_PC       64'h0  CurrentPC value on reset
//  TIMEOUT_CYCLES 16     max WAIT_RSP cycles before fault (only with FETCH_TIMEOUT_EN)
// PORTS
//  CLK          in   1   clock, rising edge
//  Reset        in   1   asynchronous, active-high reset
//  NextPC       in   64  next PC from NextPClogic, sampled in EXEC
//  Stall        in   1   hold current instruction in EXEC (hazard)
//  Halt         in   1   stop after current instruction; sampled in EXEC
//  IMemReady    in   1   instruction memory accepts request this cycle
//  IMemValid    in   1   instruction memory response valid this cycle
//  IMemData     in   32  instruction word, qualified by IMemValid
//  CurrentPC    out  64  architectural PC of instruction being fetched/executed
//  IMemReq      out  1   fetch request, IMemAddr = CurrentPC
//  IMemAddr     out  64  fetch address
//  Instruction  out  32  latched instruction word
//  InstrValid   out  1   Instruction valid for execute (EXEC state)
//  Halted       out  1   sequencer in HALT
//  FetchFault   out  1   sticky: misaligned NextPC (or timeout)
//  RetiredCount out  32  instructions committed, wraps 2^32-1 -> 0
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, CurrentPC=RESET_PC, Instruction=0, all
//    other outputs 0, RetiredCount=0. In-flight responses after reset are dropped.
//  - States IDLE, REQ, WAIT_RSP, EXEC, HALT; registered state, Moore outputs.
//  - IDLE: one cycle, -> REQ.
//  - REQ: IMemReq=1, IMemAddr=CurrentPC. IMemReady=1 -> WAIT_RSP, else stay.
//    IMemValid ignored here.
//  - WAIT_RSP: IMemValid=1 -> Instruction<=IMemData, -> EXEC; else stay.
//  - EXEC: InstrValid=1. Priority: Halt > Stall > commit.
//    Halt=1 -> HALT, PC unchanged, no retire.
//    Stall=1 -> stay in EXEC; Instruction and CurrentPC held.
//    Otherwise commit: CurrentPC<=NextPC, RetiredCount+=1.
//      NextPC[1:0]!=0 -> FetchFault<=1, -> HALT (faulting PC is visible on CurrentPC).
//      Else -> REQ.
//  - HALT: terminal until Reset. Halted=1, no requests, InstrValid=0.
//  - Minimum latency per instruction with Ready/Valid asserted immediately: 3 cycles
//    (REQ, WAIT_RSP, EXEC).
//  - PC arithmetic belongs to NextPClogic; 64-bit NextPC is taken verbatim (wrap allowed).
//  - IMemValid is expected only after an accepted request; extra responses are ignored
//    outside WAIT_RSP.
// CONFIGURATION
//  FETCH_TIMEOUT_EN defined:
//    - Counter clears on entry to WAIT_RSP and increments each WAIT_RSP cycle.
//    - Reaching TIMEOUT_CYCLES without IMemValid: FetchFault<=1, -> HALT.
//    - IMemValid in the same cycle as the limit wins (normal capture).
//  FETCH_TIMEOUT_EN undefined: no counter; WAIT_RSP waits indefinitely.
// TESTING
//  1 Reset, RESET_PC=0, Ready=Valid=1, NextPC=CurrentPC+4 ->
//    IMemAddr 0,4,8 on successive REQ; each instr 3 cycles; RetiredCount=3 after 9 cycles.
//  2 Ready low 2 cycles in REQ, Valid delayed 3 cycles ->
//    IMemReq held 3 cycles with same addr; Instruction=IMemData on Valid; InstrValid 1 cycle.
//  3 Stall=1 for 4 cycles in EXEC ->
//    InstrValid held 5 cycles, CurrentPC constant, RetiredCount +1 only at release.
//  4 NextPC=64'h1002 at commit ->
//    FetchFault=1, Halted=1, CurrentPC=64'h1002, no further IMemReq.
//  5 Halt and Stall both 1 in EXEC -> HALT next cycle, PC and RetiredCount unchanged.
//  6 Reset asserted mid-WAIT_RSP, then Valid pulse ->
//    outputs 0 and CurrentPC=RESET_PC immediately, pulse ignored, restart at IDLE.
//    With FETCH_TIMEOUT_EN and Valid never returned: FetchFault after 16 WAIT_RSP cycles.

Source files
------------

// File: rtl/pc_fetch_sequencer_if.sv
// Fetch sequencer bus: NextPC/hazard control and imem response in, request/status out.
// The sequencer takes the master modport; the core/memory environment takes slave.
interface pc_fetch_sequencer_if;
    logic [63:0] NextPC;
    logic        Stall;
    logic        Halt;
    logic        IMemReady;
    logic        IMemValid;
    logic [31:0] IMemData;
    logic [63:0] CurrentPC;
    logic        IMemReq;
    logic [63:0] IMemAddr;
    logic [31:0] Instruction;
    logic        InstrValid;
    logic        Halted;
    logic        FetchFault;
    logic [31:0] RetiredCount;

    modport master (
        input  NextPC, Stall, Halt, IMemReady, IMemValid, IMemData,
        output CurrentPC, IMemReq, IMemAddr, Instruction, InstrValid,
               Halted, FetchFault, RetiredCount
    );

    modport slave (
        output NextPC, Stall, Halt, IMemReady, IMemValid, IMemData,
        input  CurrentPC, IMemReq, IMemAddr, Instruction, InstrValid,
               Halted, FetchFault, RetiredCount
    );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and fetch sequencer: REQ -> WAIT_RSP -> EXEC -> commit NextPC.
// Optional FETCH_TIMEOUT_EN adds a WAIT_RSP watchdog that faults after TIMEOUT_CYCLES.
module pc_fetch_sequencer #(
    parameter logic [63:0] RESET_PC       = 64'h0,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  CLK,
    input  logic                  Reset,
    pc_fetch_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_RSP,
        S_EXEC,
        S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        fault_q, fault_d;
    logic [31:0] ret_q, ret_d;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;

    // Counter is zero on every entry to WAIT_RSP because it clears in all other states.
    always_comb begin
        tmo_d = '0;
        if (state_q == S_WAIT_RSP) tmo_d = tmo_q + 1'b1;
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) tmo_q <= '0;
        else       tmo_q <= tmo_d;
    end
`endif

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            fault_q <= 1'b0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            fault_q <= fault_d;
            ret_q   <= ret_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        fault_d = fault_q;
        ret_d   = ret_q;
        unique case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (bus.IMemReady) state_d = S_WAIT_RSP;
            end
            S_WAIT_RSP: begin
                if (bus.IMemValid) begin
                    instr_d = bus.IMemData;
                    state_d = S_EXEC;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end
`endif
            end
            S_EXEC: begin
                // Halt beats Stall beats commit; a misaligned target still retires.
                if (bus.Halt) begin
                    state_d = S_HALT;
                end else if (!bus.Stall) begin
                    pc_d  = bus.NextPC;
                    ret_d = ret_q + 32'd1;
                    if (bus.NextPC[1:0] != 2'b00) begin
                        fault_d = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.CurrentPC    = pc_q;
    assign bus.IMemReq      = (state_q == S_REQ);
    assign bus.IMemAddr     = (state_q == S_REQ) ? pc_q : '0;
    assign bus.Instruction  = instr_q;
    assign bus.InstrValid   = (state_q == S_EXEC);
    assign bus.Halted       = (state_q == S_HALT);
    assign bus.FetchFault   = fault_q;
    assign bus.RetiredCount = ret_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Randomized scoreboard bench for pc_fetch_sequencer: a transaction-level PC/retire model
// predicts fetch addresses and executed instructions; a negedge monitor checks them.
module tb_pc_fetch_sequencer;

    localparam logic [63:0] RESET_PC = 64'h0;
    localparam int unsigned TMO      = 16;

    localparam int unsigned ACT_COMMIT  = 0;
    localparam int unsigned ACT_HALT    = 1;
    localparam int unsigned ACT_FAULT   = 2;
    localparam int unsigned ACT_RESET   = 3;
    localparam int unsigned ACT_TIMEOUT = 4;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] ret;
    } req_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [31:0] ret;
        int unsigned cycles;
    } exe_t;

    logic clk;
    logic rst;
    pc_fetch_sequencer_if bus();

    pc_fetch_sequencer #(
        .RESET_PC       (RESET_PC),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLK   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    req_t        exp_req[$];
    exe_t        exp_exe[$];
    logic [63:0] m_pc;
    logic [31:0] m_ret;
    int unsigned mon_exec_cnt;
    bit          used_1002;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.NextPC    = '0;
        bus.Stall     = 1'b0;
        bus.Halt      = 1'b0;
        bus.IMemReady = 1'b0;
        bus.IMemValid = 1'b0;
        bus.IMemData  = '0;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_pc",      bus.CurrentPC, RESET_PC);
        chk("rst_req",     bus.IMemReq, 0);
        chk("rst_addr",    bus.IMemAddr, 0);
        chk("rst_instr",   bus.Instruction, 0);
        chk("rst_ivalid",  bus.InstrValid, 0);
        chk("rst_halted",  bus.Halted, 0);
        chk("rst_fault",   bus.FetchFault, 0);
        chk("rst_retired", bus.RetiredCount, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        #1;
        chk_reset_outputs();
        step();
        step();
        rst = 1'b0;
        exp_req.delete();
        exp_exe.delete();
        m_pc  = RESET_PC;
        m_ret = '0;
        chk("idle_no_req", bus.IMemReq, 0);
        step();
    endtask

    task automatic check_halted(input logic exp_fault);
        repeat (3) begin
            chk("halt_halted",  bus.Halted, 1);
            chk("halt_fault",   bus.FetchFault, exp_fault);
            chk("halt_pc",      bus.CurrentPC, m_pc);
            chk("halt_retired", bus.RetiredCount, m_ret);
            chk("halt_no_req",  bus.IMemReq, 0);
            chk("halt_no_iv",   bus.InstrValid, 0);
            bus.IMemReady = 1'($urandom_range(0, 1));
            bus.IMemValid = 1'($urandom_range(0, 1));
            bus.IMemData  = $urandom;
            step();
        end
        chk("drain_req_q", exp_req.size(), 0);
        chk("drain_exe_q", exp_exe.size(), 0);
    endtask

    task automatic mid_wait_reset();
        rst = 1'b1;
        #1;
        chk_reset_outputs();
        bus.IMemValid = 1'b1;
        bus.IMemData  = 32'hDEAD_BEEF;
        step();
        rst = 1'b0;
        m_pc  = RESET_PC;
        m_ret = '0;
        exp_req.delete();
        exp_exe.delete();
        exp_req.push_back('{addr: RESET_PC, ret: 32'd0});
        chk("post_rst_idle", bus.IMemReq, 0);
        step();
        chk("post_rst_req",   bus.IMemReq, 1);
        chk("post_rst_instr", bus.Instruction, 0);
        chk("post_rst_iv",    bus.InstrValid, 0);
        bus.IMemValid = 1'b0;
    endtask

    task automatic run_instr(input int unsigned act);
        logic [31:0] data;
        logic [63:0] npc;
        int unsigned s;
        int unsigned d;
        chk("req_present", bus.IMemReq, 1);
        exp_req.push_back('{addr: m_pc, ret: m_ret});
        d = $urandom_range(0, 2);
        repeat (d) begin
            bus.IMemReady = 1'b0;
            bus.IMemValid = 1'($urandom_range(0, 1));
            bus.IMemData  = $urandom;
            step();
            chk("req_held", bus.IMemReq, 1);
        end
        bus.IMemReady = 1'b1;
        bus.IMemValid = 1'($urandom_range(0, 1));
        bus.IMemData  = $urandom;
        step();
        bus.IMemReady = 1'b0;
        chk("wait_no_req", bus.IMemReq, 0);
        chk("wait_no_iv",  bus.InstrValid, 0);
        if (act == ACT_RESET) begin
            repeat ($urandom_range(1, 2)) begin
                bus.IMemValid = 1'b0;
                step();
            end
            mid_wait_reset();
            return;
        end
        if (act == ACT_TIMEOUT) begin
            repeat (TMO - 1) begin
                bus.IMemValid = 1'b0;
                step();
                chk("tmo_not_yet", bus.Halted, 0);
            end
            step();
            check_halted(1'b1);
            return;
        end
        d = $urandom_range(0, 3);
        repeat (d) begin
            bus.IMemValid = 1'b0;
            bus.IMemData  = $urandom;
            step();
            chk("wait_hold", bus.InstrValid, 0);
        end
        s    = $urandom_range(0, 3);
        data = $urandom;
        exp_exe.push_back('{pc: m_pc, instr: data, ret: m_ret, cycles: s + 1});
        bus.IMemValid = 1'b1;
        bus.IMemData  = data;
        step();
        repeat (s) begin
            bus.Stall     = 1'b1;
            bus.Halt      = 1'b0;
            bus.IMemValid = 1'($urandom_range(0, 1));
            bus.IMemData  = $urandom;
            bus.NextPC    = {$urandom, $urandom};
            step();
        end
        bus.Stall     = 1'b0;
        bus.IMemValid = 1'b0;
        case (act)
            ACT_COMMIT: begin
                if ($urandom_range(0, 3) == 0) npc = {$urandom, $urandom} & ~64'h3;
                else                           npc = m_pc + 64'd4;
                bus.NextPC = npc;
                step();
                m_pc  = npc;
                m_ret = m_ret + 32'd1;
            end
            ACT_HALT: begin
                bus.Halt   = 1'b1;
                bus.Stall  = 1'($urandom_range(0, 1));
                bus.NextPC = {$urandom, $urandom};
                step();
                bus.Halt  = 1'b0;
                bus.Stall = 1'b0;
                check_halted(1'b0);
            end
            default: begin
                if (!used_1002) begin
                    npc       = 64'h1002;
                    used_1002 = 1'b1;
                end else begin
                    npc = {$urandom, $urandom};
                    if (npc[1:0] == 2'b00) npc[0] = 1'b1;
                end
                bus.NextPC = npc;
                step();
                m_pc  = npc;
                m_ret = m_ret + 32'd1;
                check_halted(1'b1);
            end
        endcase
    endtask

    // Scoreboard monitor: checks every REQ cycle and every EXEC cycle against queue heads.
    initial begin
        mon_exec_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_exec_cnt = 0;
            end else begin
                if (bus.IMemReq) begin
                    if (exp_req.size() == 0) begin
                        chk("req_unexpected", bus.IMemReq, 0);
                    end else begin
                        chk("req_addr",    bus.IMemAddr, exp_req[0].addr);
                        chk("req_pc",      bus.CurrentPC, exp_req[0].addr);
                        chk("req_retired", bus.RetiredCount, exp_req[0].ret);
                        if (bus.IMemReady) void'(exp_req.pop_front());
                    end
                end
                if (bus.InstrValid) begin
                    if (exp_exe.size() == 0) begin
                        chk("exec_unexpected", bus.InstrValid, 0);
                    end else begin
                        chk("exec_instr",   bus.Instruction, exp_exe[0].instr);
                        chk("exec_pc",      bus.CurrentPC, exp_exe[0].pc);
                        chk("exec_retired", bus.RetiredCount, exp_exe[0].ret);
                        mon_exec_cnt++;
                    end
                end else if (mon_exec_cnt > 0) begin
                    if (exp_exe.size() != 0) begin
                        chk("exec_cycles", mon_exec_cnt, exp_exe[0].cycles);
                        void'(exp_exe.pop_front());
                    end
                    mon_exec_cnt = 0;
                end
            end
        end
    end

    initial begin
        int unsigned nkind;
        int unsigned kinds[4];
        kinds[0]  = ACT_FAULT;
        kinds[1]  = ACT_HALT;
        kinds[2]  = ACT_RESET;
        kinds[3]  = ACT_TIMEOUT;
`ifdef FETCH_TIMEOUT_EN
        nkind = 4;
`else
        nkind = 3;
`endif
        used_1002 = 1'b0;
        rst = 1'b0;
        idle_inputs();
        #2;
        for (int ph = 0; ph < 3 * int'(nkind); ph++) begin
            int unsigned n_instr;
            n_instr = $urandom_range(3, 8);
            do_reset();
            for (int unsigned i = 0; i < n_instr; i++) run_instr(ACT_COMMIT);
            run_instr(kinds[ph % int'(nkind)]);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
